// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - core request/response and RAM strobe bundle for mem_access_ctrl
interface mem_access_ctrl_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic          mem_read;
    logic          mem_wren;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    // Controller view: accepts core requests, drives the RAM strobes
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_ready,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_read, mem_wren, mem_addr, mem_wdata
    );

    // Environment view: core issues requests, RAM returns data
    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_read, mem_wren, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-request RAM access controller; optional RD timeout under MEM_CTRL_TIMEOUT_EN
module mem_access_ctrl #(
    parameter int AW = 16,
    parameter int DW = 16
`ifdef MEM_CTRL_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 15
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic          r_mem_read;
    logic          r_mem_wren;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_resp_rdata;
    logic          w_accept;
    logic          w_timeout;

    assign w_accept = bus.req_valid && (r_state == S_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: one request in flight, RESP always lasts exactly one cycle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = bus.req_we ? S_WR : S_RD;
            S_RD:    if (bus.mem_ready || w_timeout) w_next_state = S_RESP;
            S_WR:    w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Request capture, RAM strobes and response data; mem_ready only matters in RD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_read   <= 1'b0;
            r_mem_wren   <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_resp_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mem_addr  <= bus.req_addr;
                        r_mem_wdata <= bus.req_wdata;
                        r_mem_read  <= ~bus.req_we;
                        r_mem_wren  <= bus.req_we;
                    end
                end
                S_RD: begin
                    if (bus.mem_ready) begin
                        r_resp_rdata <= bus.mem_rdata;
                        r_mem_read   <= 1'b0;
                    end else if (w_timeout) begin
                        r_resp_rdata <= '0;
                        r_mem_read   <= 1'b0;
                    end
                end
                S_WR: begin
                    r_mem_wren   <= 1'b0;
                    r_resp_rdata <= '0;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MEM_CTRL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_to_cnt;
    logic          r_resp_err;

    // The edge that would bring the count to the limit ends RD
    assign w_timeout = (r_state == S_RD) && (r_to_cnt == TO_LAST);

    // Cycles spent in RD; error flag set on timeout (data wins a tie), cleared leaving RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt   <= '0;
            r_resp_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_to_cnt <= '0;
            end else if (r_state == S_RD) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_timeout && !bus.mem_ready) begin
                r_resp_err <= 1'b1;
            end else if (r_state == S_RESP) begin
                r_resp_err <= 1'b0;
            end
        end
    end

    assign bus.resp_err = r_resp_err;
`else
    assign w_timeout    = 1'b0;
    assign bus.resp_err = 1'b0;
`endif

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.mem_read   = r_mem_read;
    assign bus.mem_wren   = r_mem_wren;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl with a registered-ready RAM model
module tb_mem_access_ctrl;
    localparam int AW = 16;
    localparam int DW = 16;
`ifdef MEM_CTRL_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 1000;
`endif

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        int          ws;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    mem_access_ctrl #(
        .AW(AW),
        .DW(DW)
`ifdef MEM_CTRL_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(TO)
`endif
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // RAM model: ready registered from readMem, asserted ram_ws cycles after readMem rises
    logic [15:0] ram [0:255];
    logic [15:0] ram_out   = 16'h0;
    logic        ram_ready = 1'b0;
    int          ram_cnt   = 0;
    int          ram_ws    = 1;
    bit          ram_never = 1'b0;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] <= 16'h5A00 | 16'(i);
    end

    always @(posedge clk) begin
        if (bus.mem_wren) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
        ram_out   <= ram[bus.mem_addr[7:0]];
        ram_ready <= bus.mem_read && !ram_never && (ram_cnt + 1 >= ram_ws);
        ram_cnt   <= bus.mem_read ? ram_cnt + 1 : 0;
    end

    assign bus.mem_rdata = ram_out;
    assign bus.mem_ready = ram_ready;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    exp_t        exp_q[$];
    int          acc_q[$];
    int          acc_log[$];
    int          cyc         = 0;
    int          resp_seen   = 0;
    int          inv_bad     = 0;
    int          rd_run      = 0;
    int          wr_run      = 0;
    int          exp_rd_len  = 2;
    logic [15:0] exp_wr_addr = 16'h0;
    logic [15:0] exp_wr_data = 16'h0;

    // Accept log: entry is the cycle number before the accepting edge
    always @(posedge clk) begin
        if (rst_n && bus.req_valid && bus.req_ready) begin
            acc_q.push_back(cyc);
            acc_log.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    // Response scoreboard and strobe-length monitor
    always @(negedge clk) begin
        exp_t e;
        int   a;
        if (!rst_n) begin
            rd_run = 0;
            wr_run = 0;
        end else begin
            if (bus.req_ready && (bus.resp_valid || bus.mem_read || bus.mem_wren)) inv_bad++;
            if (bus.resp_valid) begin
                check("resp_expected", 32'(exp_q.size() > 0 && acc_q.size() > 0), 1);
                if (exp_q.size() > 0 && acc_q.size() > 0) begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    check("resp_rdata", 32'(bus.resp_rdata), 32'(e.rdata));
                    check("resp_err", 32'(bus.resp_err), 32'(e.err));
                    check("resp_latency", cyc - a, e.lat);
                end
                resp_seen++;
            end
            if (bus.mem_read) begin
                rd_run++;
            end else if (rd_run != 0) begin
                check("mem_read_len", rd_run, exp_rd_len);
                rd_run = 0;
            end
            if (bus.mem_wren) begin
                wr_run++;
                check("wr_mem_addr", 32'(bus.mem_addr), 32'(exp_wr_addr));
                check("wr_mem_wdata", 32'(bus.mem_wdata), 32'(exp_wr_data));
            end else if (wr_run != 0) begin
                check("mem_wren_len", wr_run, 1);
                wr_run = 0;
            end
        end
    end

    task automatic issue(input logic we, input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] er, input logic ee, input int lat, input int rdlen);
        int   start;
        int   g;
        exp_t e;
        @(negedge clk);
        exp_rd_len  = rdlen;
        exp_wr_addr = a;
        exp_wr_data = d;
        e.rdata = er;
        e.err   = ee;
        e.lat   = lat;
        exp_q.push_back(e);
        start = resp_seen;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        g = 0;
        while (!bus.req_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        g = 0;
        while (resp_seen == start && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("resp_arrived", 32'(resp_seen != start), 1);
    endtask

    task automatic apply_vec(input vec_t v);
        ram_ws = v.ws;
        if (v.we) begin
            issue(1'b1, v.addr, v.wdata, 16'h0, 1'b0, 2, 0);
        end else if (v.ws + 1 <= TO) begin
            issue(1'b0, v.addr, v.wdata, v.exp_rdata, 1'b0, v.ws + 2, v.ws + 1);
        end else begin
            issue(1'b0, v.addr, v.wdata, 16'h0, 1'b1, TO + 1, TO);
        end
    endtask

    initial begin
        vec_t vecs[8];
        int   base;
        int   start;
        int   g;
        exp_t e;

        vecs[0] = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1};
        vecs[1] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1};
        vecs[2] = '{1'b1, 16'h00FF, 16'h1234, 16'h0000, 1};
        vecs[3] = '{1'b0, 16'h00FF, 16'hFFFF, 16'h1234, 1};
        vecs[4] = '{1'b0, 16'h0005, 16'h0000, 16'h5A05, 5};
        vecs[5] = '{1'b1, 16'h0000, 16'hFFFF, 16'h0000, 1};
        vecs[6] = '{1'b0, 16'h0000, 16'h0000, 16'hFFFF, 1};
        vecs[7] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 3};

        // Reset held with a request pending: nothing accepted, outputs at reset values
        rst_n         = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 16'h1234;
        bus.req_wdata = 16'h5678;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_req_ready", 32'(bus.req_ready), 1);
            check("rst_strobes", 32'({bus.mem_read, bus.mem_wren, bus.resp_valid, bus.resp_err}), 0);
            check("rst_addr_wdata", {bus.mem_addr, bus.mem_wdata}, 0);
            check("rst_resp_rdata", 32'(bus.resp_rdata), 0);
        end
        bus.req_valid = 1'b0;
        rst_n         = 1'b1;

        for (int i = 0; i < 8; i++) apply_vec(vecs[i]);

        // Back-to-back reads with req_valid held high
        ram_ws     = 1;
        exp_rd_len = 2;
        base       = acc_log.size();
        start      = resp_seen;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            bus.req_addr = 16'(k);
            e.rdata = 16'h5A00 | 16'(k);
            e.err   = 1'b0;
            e.lat   = 3;
            exp_q.push_back(e);
            g = 0;
            while (!bus.req_ready && g < 100) begin
                @(negedge clk);
                g++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        g = 0;
        while (resp_seen < start + 3 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("b2b_responses", resp_seen - start, 3);
        check("b2b_accepts", acc_log.size() - base, 3);
        if (acc_log.size() >= base + 3) begin
            check("b2b_spacing_1", acc_log[base+1] - acc_log[base], 4);
            check("b2b_spacing_2", acc_log[base+2] - acc_log[base+1], 4);
        end

`ifdef MEM_CTRL_TIMEOUT_EN
        // RAM never answers: error response after TO cycles in RD, then normal service
        ram_never = 1'b1;
        issue(1'b0, 16'h0020, 16'h0000, 16'h0000, 1'b1, TO + 1, TO);
        ram_never = 1'b0;
        ram_ws    = 1;
        issue(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 3, 2);
`endif

        // Asynchronous reset between edges while in RD
        ram_ws = 1;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h0033;
        @(posedge clk);
        #1;
        check("pre_rst_mem_read", 32'(bus.mem_read), 1);
        check("pre_rst_mem_addr", 32'(bus.mem_addr), 32'h33);
        #1;
        bus.req_valid = 1'b0;
        rst_n         = 1'b0;
        #1;
        check("arst_mem_read", 32'(bus.mem_read), 0);
        check("arst_resp_valid", 32'(bus.resp_valid), 0);
        check("arst_mem_addr", 32'(bus.mem_addr), 0);
        check("arst_req_ready", 32'(bus.req_ready), 1);
        acc_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start = resp_seen;
        repeat (8) @(negedge clk);
        check("no_resp_after_rst", resp_seen - start, 0);

        issue(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 3, 2);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        check("ready_only_when_idle", inv_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
